// File: rtl/mem_port_arb.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arb
// Description : Round-robin arbiter sharing one memory read/write port among
//               four requesters. Each grant is held for a bounded burst, and
//               read beats are tagged so returning data reaches its issuer.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arb #(
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16,
    parameter int TAG_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            req_wr_en,
    input  logic [3:0]            req_rd_en,
    input  logic [4*ADDR_W-1:0]   req_wr_addr,
    input  logic [4*ADDR_W-1:0]   req_rd_addr,
    input  logic [4*DATA_W-1:0]   req_wr_data,
    output logic [3:0]            req_wr_rdy,
    output logic [3:0]            req_rd_rdy,
    output logic [DATA_W-1:0]     req_rd_data,
    output logic [3:0]            req_rd_valid,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_rdy,
    input  logic                  rd_rdy,
    input  logic [DATA_W-1:0]     rd_data,
    input  logic                  rd_data_valid,
    output logic [1:0]            owner,
    output logic                  busy,
    output logic                  tag_err
);

    localparam int c_cnt_w = $clog2(MAX_BURST + 1);
    localparam int c_idx_w = $clog2(TAG_DEPTH);
    localparam int c_ptr_w = c_idx_w + 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(MAX_BURST - 1);
    localparam logic [c_ptr_w-1:0] c_depth = c_ptr_w'(TAG_DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_owner;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [1:0]           r_tags [TAG_DEPTH];
    logic                 r_tag_err;

    logic [3:0]           w_req_any;
    logic [1:0]           w_sel;
    logic [1:0]           w_idx;
    logic                 w_found;
    logic                 w_own_en;
    logic                 w_push;
    logic                 w_beat;
    logic                 w_pop;
    logic                 w_tag_empty;
    logic                 w_tag_full;
    logic [1:0]           w_head;

    assign w_req_any   = req_wr_en | req_rd_en;
    assign w_tag_empty = (r_wr_ptr == r_rd_ptr);
    assign w_tag_full  = ((r_wr_ptr - r_rd_ptr) == c_depth);
    assign w_head      = r_tags[r_rd_ptr[c_idx_w-1:0]];
    assign w_pop       = rd_data_valid & ~w_tag_empty;

    assign req_rd_valid = w_pop ? (4'b0001 << w_head) : 4'b0000;
    assign req_rd_data  = w_pop ? rd_data : '0;
    assign owner        = r_owner;
    assign busy         = (r_state == S_OWN);
    assign tag_err      = r_tag_err;

    // Round-robin pick: first requester after the last owner, wrapping to it.
    always_comb begin
        w_sel   = r_owner;
        w_found = 1'b0;
        w_idx   = r_owner;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_owner + 2'(k);
            if (!w_found && w_req_any[w_idx]) begin
                w_sel   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    // Steer the owner onto the memory port; reads are held off while tags are full.
    always_comb begin
        req_wr_rdy = 4'b0000;
        req_rd_rdy = 4'b0000;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        wr_addr    = '0;
        rd_addr    = '0;
        wr_data    = '0;
        w_push     = 1'b0;
        w_beat     = 1'b0;
        w_own_en   = 1'b0;
        if (r_state == S_OWN) begin
            wr_en               = req_wr_en[r_owner];
            rd_en               = req_rd_en[r_owner] & ~w_tag_full;
            wr_addr             = req_wr_addr[int'(r_owner)*ADDR_W +: ADDR_W];
            rd_addr             = req_rd_addr[int'(r_owner)*ADDR_W +: ADDR_W];
            wr_data             = req_wr_data[int'(r_owner)*DATA_W +: DATA_W];
            req_wr_rdy[r_owner] = wr_rdy;
            req_rd_rdy[r_owner] = rd_rdy & ~w_tag_full;
            w_push              = rd_en & rd_rdy;
            w_beat              = (wr_en & wr_rdy) | w_push;
            w_own_en            = req_wr_en[r_owner] | req_rd_en[r_owner];
        end
    end

    // Next state: grant on any request, release when owner goes quiet or burst ends.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_OWN;
            S_OWN:   if (!w_own_en || (w_beat && (r_count == c_last))) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, owner and burst-beat counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_owner <= 2'd3;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE) begin
                r_count <= '0;
                if (w_found) r_owner <= w_sel;
            end else if (w_beat) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Tag FIFO pointers and the sticky error for returns with no tag pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_tag_err <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (rd_data_valid && w_tag_empty) r_tag_err <= 1'b1;
        end
    end

    // Tag storage: the owner index of each accepted read beat.
    always_ff @(posedge clk) begin
        if (w_push) r_tags[r_wr_ptr[c_idx_w-1:0]] <= r_owner;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arb
// Description : Directed self-checking bench for mem_port_arb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arb;

    localparam int ADDR_W    = 24;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 16;
    localparam int TAG_DEPTH = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic [3:0]          req_wr_en, req_rd_en;
    logic [4*ADDR_W-1:0] req_wr_addr, req_rd_addr;
    logic [4*DATA_W-1:0] req_wr_data;
    logic [3:0]          req_wr_rdy, req_rd_rdy, req_rd_valid;
    logic [DATA_W-1:0]   req_rd_data;
    logic                wr_en, rd_en;
    logic [ADDR_W-1:0]   wr_addr, rd_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_rdy, rd_rdy;
    logic [DATA_W-1:0]   rd_data;
    logic                rd_data_valid;
    logic [1:0]          owner;
    logic                busy, tag_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mem_port_arb #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .req_wr_en(req_wr_en), .req_rd_en(req_rd_en),
        .req_wr_addr(req_wr_addr), .req_rd_addr(req_rd_addr), .req_wr_data(req_wr_data),
        .req_wr_rdy(req_wr_rdy), .req_rd_rdy(req_rd_rdy),
        .req_rd_data(req_rd_data), .req_rd_valid(req_rd_valid),
        .wr_en(wr_en), .rd_en(rd_en), .wr_addr(wr_addr), .rd_addr(rd_addr), .wr_data(wr_data),
        .wr_rdy(wr_rdy), .rd_rdy(rd_rdy), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .owner(owner), .busy(busy), .tag_err(tag_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_inputs();
        req_wr_en = '0; req_rd_en = '0;
        req_wr_addr = '0; req_rd_addr = '0; req_wr_data = '0;
        wr_rdy = 1'b0; rd_rdy = 1'b0; rd_data = '0; rd_data_valid = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        req_wr_en = 4'b1111; req_rd_en = 4'b1111;
        wr_rdy = 1'b1; rd_rdy = 1'b1; rd_data_valid = 1'b1; rd_data = 32'hFFFF_FFFF;
        #22;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (owner !== 2'd3) $display("FAIL reset_owner: got %0d expected 3", owner); else pass_cnt++;
        total_cnt++; if (req_wr_rdy !== 4'b0) $display("FAIL reset_wr_rdy: got %b expected 0000", req_wr_rdy); else pass_cnt++;
        total_cnt++; if (req_rd_rdy !== 4'b0) $display("FAIL reset_rd_rdy: got %b expected 0000", req_rd_rdy); else pass_cnt++;
        total_cnt++; if (wr_en !== 1'b0 || rd_en !== 1'b0) $display("FAIL reset_mem_en: got wr=%b rd=%b expected 0 0", wr_en, rd_en); else pass_cnt++;
        total_cnt++; if (req_rd_valid !== 4'b0) $display("FAIL reset_rd_valid: got %b expected 0000", req_rd_valid); else pass_cnt++;
        total_cnt++; if (req_rd_data !== 32'h0) $display("FAIL reset_rd_data: got %h expected 0", req_rd_data); else pass_cnt++;
        total_cnt++; if (tag_err !== 1'b0) $display("FAIL reset_tag_err: got %b expected 0", tag_err); else pass_cnt++;
        clear_inputs();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_burst();
        logic acc_hist [32];
        logic rdy_hist [32];
        logic busy_hist[32];
        int acc = 0, mism = 0, c = 0, first, run1 = 0, gap = 0, run2 = 0, gap_start;
        wr_rdy = 1'b1; rd_rdy = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            req_wr_en = (acc < 20) ? 4'b0001 : 4'b0000;
            req_wr_addr[ADDR_W-1:0] = 24'(32'h0010_0000 + acc);
            req_wr_data[DATA_W-1:0] = 32'hA5A5_0000 + 32'(acc);
            #1;
            rdy_hist[i]  = req_wr_rdy[0];
            busy_hist[i] = busy;
            acc_hist[i]  = req_wr_en[0] & req_wr_rdy[0];
            if (acc_hist[i]) begin
                if (wr_en !== 1'b1 || wr_addr !== 24'(32'h0010_0000 + acc) ||
                    wr_data !== 32'hA5A5_0000 + 32'(acc)) mism++;
                acc++;
            end
            if (req_wr_rdy[3:1] !== 3'b000 || req_rd_rdy[3:1] !== 3'b000) mism++;
        end
        while (c < 32 && !acc_hist[c]) c++;
        first = c;
        while (c < 32 && acc_hist[c]) begin run1++; c++; end
        gap_start = c;
        while (c < 32 && !acc_hist[c]) begin gap++; c++; end
        while (c < 32 && acc_hist[c]) begin run2++; c++; end
        total_cnt++; if (busy_hist[0] !== 1'b0) $display("FAIL burst_no_same_cycle_grant: got busy=%b expected 0", busy_hist[0]); else pass_cnt++;
        total_cnt++; if (first != 1) $display("FAIL burst_grant_latency: got cycle %0d expected 1", first); else pass_cnt++;
        total_cnt++; if (run1 != 16) $display("FAIL burst_first_len: got %0d expected 16", run1); else pass_cnt++;
        total_cnt++; if (gap != 1) $display("FAIL burst_idle_gap: got %0d expected 1", gap); else pass_cnt++;
        total_cnt++; if (rdy_hist[gap_start] !== 1'b0 || busy_hist[gap_start] !== 1'b0)
            $display("FAIL burst_bubble: got rdy=%b busy=%b expected 0 0", rdy_hist[gap_start], busy_hist[gap_start]); else pass_cnt++;
        total_cnt++; if (run2 != 4) $display("FAIL burst_second_len: got %0d expected 4", run2); else pass_cnt++;
        total_cnt++; if (mism != 0) $display("FAIL burst_port_mux: got %0d errors expected 0", mism); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || owner !== 2'd0) $display("FAIL burst_end_state: got busy=%b owner=%0d expected 0 0", busy, owner); else pass_cnt++;
        clear_inputs();
    endtask

    task automatic test_round_robin();
        logic [1:0] gown [6];
        int gbeats [6];
        int grants = 0, viol = 0;
        logic prev_busy = 1'b0;
        for (int i = 0; i < 6; i++) begin gbeats[i] = 0; gown[i] = 2'd0; end
        apply_reset();
        wr_rdy = 1'b1;
        for (int i = 0; i < 103; i++) begin
            @(negedge clk);
            req_wr_en = 4'b0111;
            #1;
            if (busy && !prev_busy) begin
                if (grants < 6) gown[grants] = owner;
                grants++;
            end
            prev_busy = busy;
            if (busy && grants >= 1 && grants <= 6) gbeats[grants-1] += $countones(req_wr_en & req_wr_rdy);
            if (busy && req_wr_rdy !== (4'b0001 << owner)) viol++;
            if (!busy && req_wr_rdy !== 4'b0000) viol++;
        end
        total_cnt++; if (grants != 6) $display("FAIL rr_grant_count: got %0d expected 6", grants); else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            total_cnt++; if (gown[i] !== 2'(i % 3)) $display("FAIL rr_order[%0d]: got %0d expected %0d", i, gown[i], i % 3); else pass_cnt++;
            total_cnt++; if (gbeats[i] != 16) $display("FAIL rr_beats[%0d]: got %0d expected 16", i, gbeats[i]); else pass_cnt++;
        end
        total_cnt++; if (viol != 0) $display("FAIL rr_rdy_onehot: got %0d violations expected 0", viol); else pass_cnt++;
        clear_inputs();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_tag_full();
        int acc = 0, mism = 0, bad = 0;
        wr_rdy = 1'b1; rd_rdy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            req_rd_en = 4'b0100;
            req_rd_addr[2*ADDR_W +: ADDR_W] = 24'(32'h0020_0000 + acc);
            #1;
            if (req_rd_rdy[2]) begin
                if (rd_en !== 1'b1 || rd_addr !== 24'(32'h0020_0000 + acc)) mism++;
                acc++;
            end
        end
        total_cnt++; if (acc != 8) $display("FAIL full_reads_accepted: got %0d expected 8", acc); else pass_cnt++;
        total_cnt++; if (mism != 0) $display("FAIL full_rd_mux: got %0d errors expected 0", mism); else pass_cnt++;
        total_cnt++; if (req_rd_rdy[2] !== 1'b0 || rd_en !== 1'b0) $display("FAIL full_stall: got rdy=%b rd_en=%b expected 0 0", req_rd_rdy[2], rd_en); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL full_grant_held: got busy=%b expected 1", busy); else pass_cnt++;
        @(negedge clk);
        rd_data_valid = 1'b1; rd_data = 32'hCAFE_0001;
        #1;
        total_cnt++; if (req_rd_valid !== 4'b0100) $display("FAIL full_return_valid: got %b expected 0100", req_rd_valid); else pass_cnt++;
        total_cnt++; if (req_rd_data !== 32'hCAFE_0001) $display("FAIL full_return_data: got %h expected cafe0001", req_rd_data); else pass_cnt++;
        @(negedge clk);
        rd_data_valid = 1'b0; rd_data = '0;
        #1;
        total_cnt++; if (req_rd_rdy[2] !== 1'b1 || rd_en !== 1'b1) $display("FAIL full_slot_freed: got rdy=%b rd_en=%b expected 1 1", req_rd_rdy[2], rd_en); else pass_cnt++;
        @(negedge clk);
        req_rd_en = 4'b0000;
        #1;
        total_cnt++; if (req_rd_rdy[2] !== 1'b0) $display("FAIL full_again: got rdy=%b expected 0", req_rd_rdy[2]); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rd_data_valid = 1'b1; rd_data = 32'hCAFE_0010 + 32'(i);
            #1;
            if (req_rd_valid !== 4'b0100) bad++;
        end
        total_cnt++; if (bad != 0) $display("FAIL full_drain_valid: got %0d bad returns expected 0", bad); else pass_cnt++;
        @(negedge clk);
        rd_data_valid = 1'b0;
        #1;
        total_cnt++; if (tag_err !== 1'b0) $display("FAIL full_no_tag_err: got %b expected 0", tag_err); else pass_cnt++;
        clear_inputs();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_interleave();
        int a1 = 0, a3 = 0, issued = 0, ret = 0;
        logic [3:0] exp_v;
        wr_rdy = 1'b1; rd_rdy = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (a1 < 3)      req_rd_en = 4'b0010;
            else if (a3 < 2) req_rd_en = 4'b1000;
            else             req_rd_en = 4'b0000;
            req_rd_addr[1*ADDR_W +: ADDR_W] = 24'(32'h0031_0000 + a1);
            req_rd_addr[3*ADDR_W +: ADDR_W] = 24'(32'h0033_0000 + a3);
            rd_data_valid = (ret < issued);
            rd_data = 32'hDA7A_000A + 32'(ret);
            #1;
            if (rd_data_valid) begin
                exp_v = (ret < 3) ? 4'b0010 : 4'b1000;
                total_cnt++;
                if (req_rd_valid !== exp_v || req_rd_data !== 32'hDA7A_000A + 32'(ret))
                    $display("FAIL interleave_return[%0d]: got valid=%b data=%h expected valid=%b data=%h",
                             ret, req_rd_valid, req_rd_data, exp_v, 32'hDA7A_000A + 32'(ret));
                else pass_cnt++;
                ret++;
            end
            if (req_rd_en[1] && req_rd_rdy[1]) begin a1++; issued++; end
            if (req_rd_en[3] && req_rd_rdy[3]) begin a3++; issued++; end
        end
        total_cnt++; if (a1 != 3 || a3 != 2) $display("FAIL interleave_issue: got r1=%0d r3=%0d expected 3 2", a1, a3); else pass_cnt++;
        total_cnt++; if (ret != 5) $display("FAIL interleave_returns: got %0d expected 5", ret); else pass_cnt++;
        clear_inputs();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_tag_err();
        @(negedge clk);
        rd_data_valid = 1'b1; rd_data = 32'hDEAD_BEEF;
        #1;
        total_cnt++; if (req_rd_valid !== 4'b0000) $display("FAIL err_drop_valid: got %b expected 0000", req_rd_valid); else pass_cnt++;
        @(negedge clk);
        rd_data_valid = 1'b0;
        #1;
        total_cnt++; if (tag_err !== 1'b1) $display("FAIL err_set: got %b expected 1", tag_err); else pass_cnt++;
        repeat (3) @(negedge clk);
        #1;
        total_cnt++; if (tag_err !== 1'b1) $display("FAIL err_sticky: got %b expected 1", tag_err); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total_cnt++; if (tag_err !== 1'b0) $display("FAIL err_cleared: got %b expected 0", tag_err); else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset_mid_burst();
        int ar = 0;
        wr_rdy = 1'b1; rd_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ar < 3) begin req_rd_en = 4'b0010; req_wr_en = 4'b0000; end
            else        begin req_rd_en = 4'b0000; req_wr_en = 4'b0010; end
            #1;
            if (req_rd_en[1] && req_rd_rdy[1]) ar++;
        end
        total_cnt++; if (ar != 3 || busy !== 1'b1) $display("FAIL mid_setup: got reads=%0d busy=%b expected 3 1", ar, busy); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total_cnt++; if (busy !== 1'b0 || owner !== 2'd3) $display("FAIL mid_reset_state: got busy=%b owner=%0d expected 0 3", busy, owner); else pass_cnt++;
        total_cnt++; if (wr_en !== 1'b0 || req_wr_rdy !== 4'b0) $display("FAIL mid_reset_port: got wr_en=%b wr_rdy=%b expected 0 0000", wr_en, req_wr_rdy); else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        req_wr_en = 4'b0000; req_rd_en = 4'b0000;
        @(negedge clk);
        rd_data_valid = 1'b1; rd_data = 32'h1234_5678;
        #1;
        total_cnt++; if (req_rd_valid !== 4'b0000) $display("FAIL mid_stale_return: got %b expected 0000", req_rd_valid); else pass_cnt++;
        @(negedge clk);
        rd_data_valid = 1'b0;
        #1;
        total_cnt++; if (tag_err !== 1'b1) $display("FAIL mid_tag_err: got %b expected 1", tag_err); else pass_cnt++;
        @(negedge clk);
        req_wr_en = 4'b1111;
        #1;
        @(negedge clk);
        #1;
        total_cnt++; if (busy !== 1'b1 || owner !== 2'd0 || req_wr_rdy !== 4'b0001)
            $display("FAIL mid_next_grant: got busy=%b owner=%0d rdy=%b expected 1 0 0001", busy, owner, req_wr_rdy); else pass_cnt++;
        clear_inputs();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_burst();
        test_round_robin();
        test_tag_full();
        test_interleave();
        test_tag_err();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
